// File: rtl/uvma_clknrst_rst_pulse_mon.sv
// Reset-line pulse monitor: synchronizes an observed reset, measures each reset/run phase
// in clk cycles and queues one timestamped event per edge in a FWFT valid/ready FIFO.
module uvma_clknrst_rst_pulse_mon #(
    parameter int unsigned MIN_RST_CYCLES = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TS_W           = 32,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mon_rst_n,
    input  logic                       clr_sticky,
    input  logic                       evt_ready,
    output logic                       evt_valid,
    output logic [1:0]                 evt_kind,
    output logic [CNT_W-1:0]           evt_width,
    output logic [TS_W-1:0]            evt_ts,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       err_short,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] KIND_ASSERT   = 2'd0;
    localparam logic [1:0] KIND_DEASSERT = 2'd1;
    localparam logic [1:0] KIND_SHORT    = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CNT_W-1:0] width;
        logic [TS_W-1:0]  ts;
    } evt_t;

    typedef enum logic {
        IN_RST = 1'b0,
        RUN    = 1'b1
    } state_e;

    state_e           state, state_nxt;
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic [TS_W-1:0]  ts;

    logic             push_c;
    logic             set_short_c;
    evt_t             push_data_c;

    evt_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_c, full_c, wr_en_c, drop_c;

    // Two-flop synchronizer for the asynchronous observed reset line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= mon_rst_n;
            sync2 <= sync1;
        end
    end

    // Phase FSM state register, phase length counter and free-running timestamp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IN_RST;
            cnt   <= CNT_W'(1);
            ts    <= '0;
        end else begin
            state <= state_nxt;
            ts    <= ts + TS_W'(1);
            if (push_c) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Edge detection against the current phase; builds the event to enqueue.
    always_comb begin
        state_nxt         = state;
        push_c            = 1'b0;
        set_short_c       = 1'b0;
        push_data_c.kind  = KIND_ASSERT;
        push_data_c.width = cnt;
        push_data_c.ts    = ts;
        if (state == IN_RST) begin
            if (sync2) begin
                state_nxt = RUN;
                push_c    = 1'b1;
                if (cnt < CNT_W'(MIN_RST_CYCLES)) begin
                    push_data_c.kind = KIND_SHORT;
                    set_short_c      = 1'b1;
                end else begin
                    push_data_c.kind = KIND_DEASSERT;
                end
            end
        end else begin
            if (!sync2) begin
                state_nxt        = IN_RST;
                push_c           = 1'b1;
                push_data_c.kind = KIND_ASSERT;
            end
        end
    end

    assign pop_c   = evt_ready && (count != '0);
    assign full_c  = (count == CW'(DEPTH));
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    // Event FIFO storage and pointers; a full FIFO still accepts a push when popped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= push_data_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new set event takes priority over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_short <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (set_short_c) begin
                err_short <= 1'b1;
            end else if (clr_sticky) begin
                err_short <= 1'b0;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_sticky) begin
                overflow <= 1'b0;
            end
        end
    end

    assign evt_valid = (count != '0);
    assign evt_count = count;
    assign evt_kind  = mem[rd_ptr].kind;
    assign evt_width = mem[rd_ptr].width;
    assign evt_ts    = mem[rd_ptr].ts;

endmodule

// File: tb/tb_uvma_clknrst_rst_pulse_mon.sv
// Bench for uvma_clknrst_rst_pulse_mon: directed phase table, corner sequences and
// randomized phases, all checked every cycle against an edge-index/queue reference model.
module tb_uvma_clknrst_rst_pulse_mon;

    localparam int unsigned MIN_RST = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TS_W    = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic             mon_rst_n;
    logic             clr_sticky;
    logic             evt_ready;
    logic             evt_valid;
    logic [1:0]       evt_kind;
    logic [CNT_W-1:0] evt_width;
    logic [TS_W-1:0]  evt_ts;
    logic [2:0]       evt_count;
    logic             err_short;
    logic             overflow;

    uvma_clknrst_rst_pulse_mon #(
        .MIN_RST_CYCLES(MIN_RST),
        .CNT_W         (CNT_W),
        .TS_W          (TS_W),
        .DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mon_rst_n (mon_rst_n),
        .clr_sticky(clr_sticky),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_kind  (evt_kind),
        .evt_width (evt_width),
        .evt_ts    (evt_ts),
        .evt_count (evt_count),
        .err_short (err_short),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CNT_W-1:0] width;
        logic [TS_W-1:0]  ts;
    } ev_t;

    typedef struct {
        bit         level;
        int         hold;
        bit         has_evt;
        logic [1:0] kind;
        int         width;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edge index since release, synced sample = mon_rst_n two edges back,
    // event width = distance between transition edges, ts = edge index - 1.
    int unsigned m_e, m_last, m_w;
    bit          m_level, m_synced, m_push, m_pop, m_short;
    bit          mon_hist[$];
    ev_t         m_q[$];
    ev_t         m_ev;
    bit          m_err, m_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_e = 0;
            m_last = 0;
            m_level = 1'b0;
            mon_hist.delete();
            m_q.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_e++;
            m_synced = (mon_hist.size() >= 2) ? mon_hist[mon_hist.size()-2] : 1'b0;
            mon_hist.push_back(mon_rst_n);
            if (mon_hist.size() > 2) void'(mon_hist.pop_front());
            m_push  = 1'b0;
            m_short = 1'b0;
            if (m_synced != m_level) begin
                m_w = m_e - m_last;
                if (m_w > CNT_MAX) m_w = CNT_MAX;
                m_ev.width = CNT_W'(m_w);
                m_ev.ts    = TS_W'(m_e - 1);
                if (!m_synced)         m_ev.kind = 2'd0;
                else if (m_w < MIN_RST) begin m_ev.kind = 2'd2; m_short = 1'b1; end
                else                   m_ev.kind = 2'd1;
                m_last  = m_e;
                m_level = m_synced;
                m_push  = 1'b1;
            end
            m_pop = evt_ready && (m_q.size() != 0);
            if (clr_sticky) begin
                m_err = 1'b0;
                m_ovf = 1'b0;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ev);
                else m_ovf = 1'b1;
            end
            if (m_short) m_err = 1'b1;
        end
    end

    // Every-cycle comparison against the model, plus capture of accepted events.
    ev_t seen[$];
    ev_t cap;
    always @(negedge clk) begin
        check("valid", evt_valid, 64'(m_q.size() != 0));
        check("count", evt_count, 64'(m_q.size()));
        check("err_short", err_short, m_err);
        check("overflow", overflow, m_ovf);
        if (m_q.size() != 0) begin
            check("head_kind", evt_kind, m_q[0].kind);
            check("head_width", evt_width, m_q[0].width);
            check("head_ts", evt_ts, m_q[0].ts);
        end
        if (evt_valid && evt_ready) begin
            cap.kind  = evt_kind;
            cap.width = evt_width;
            cap.ts    = evt_ts;
            seen.push_back(cap);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input bit level, input int n);
        mon_rst_n = level;
        repeat (n) tick();
    endtask

    vec_t tbl[8];
    int   k;

    initial begin
        // Expected event for each row is the one reported when that row's level appears.
        // The first phase counts the reset-release sample plus two sync stages: hold 17 -> 20.
        tbl[0] = '{1'b0, 17, 1'b0, 2'd0, 0};
        tbl[1] = '{1'b1, 30, 1'b1, 2'd1, 20};
        tbl[2] = '{1'b0,  3, 1'b1, 2'd0, 30};
        tbl[3] = '{1'b1, 12, 1'b1, 2'd2, 3};
        tbl[4] = '{1'b0,  8, 1'b1, 2'd0, 12};
        tbl[5] = '{1'b1, 10, 1'b1, 2'd1, 8};
        tbl[6] = '{1'b0,  7, 1'b1, 2'd0, 10};
        tbl[7] = '{1'b1,  5, 1'b1, 2'd2, 7};

        reset_n    = 1'b0;
        mon_rst_n  = 1'b0;
        clr_sticky = 1'b0;
        evt_ready  = 1'b0;
        repeat (3) tick();
        check("reset_valid", evt_valid, 0);
        check("reset_count", evt_count, 0);
        check("reset_kind", evt_kind, 0);
        check("reset_width", evt_width, 0);
        check("reset_ts", evt_ts, 0);
        check("reset_err", err_short, 0);
        check("reset_ovf", overflow, 0);

        // Directed phase table with a free-running consumer.
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            mon_rst_n = tbl[i].level;
            for (int j = 0; j < tbl[i].hold; j++) begin
                tick();
                if (i == 1 && j == 1) check("latency_early", evt_valid, 0);
                if (i == 1 && j == 2) check("latency", evt_valid, 1);
            end
        end
        repeat (5) tick();
        check("tbl_events", seen.size(), 7);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].has_evt && k < seen.size()) begin
                check("tbl_kind", seen[k].kind, tbl[i].kind);
                check("tbl_width", seen[k].width, 64'(tbl[i].width));
                k++;
            end
        end
        if (seen.size() > 0) check("tbl_first_ts", seen[0].ts, 19);
        check("short_sticky", err_short, 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("short_clear", err_short, 0);

        // Overflow: six edges with no consumer.
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) hold(i[0], 10);
        repeat (5) tick();
        check("ovf_count", evt_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", evt_kind, 0);
        seen.delete();
        evt_ready = 1'b1;
        repeat (4) tick();
        evt_ready = 1'b0;
        check("ovf_drained", seen.size(), 4);
        if (seen.size() == 4) begin
            check("ovf_order0", seen[0].kind, 0);
            check("ovf_order1", seen[1].kind, 1);
            check("ovf_order2", seen[2].kind, 0);
            check("ovf_order3", seen[3].kind, 1);
            check("ovf_w1", seen[1].width, 10);
            check("ovf_w3", seen[3].width, 10);
        end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("ovf_clear", overflow, 0);

        // Full FIFO with push and pop in the same cycle.
        for (int i = 0; i < 4; i++) hold(i[0], 10);
        repeat (3) tick();
        check("full_count", evt_count, 4);
        mon_rst_n = 1'b0;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pushpop_count", evt_count, 4);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_head", evt_kind, 1);
        evt_ready = 1'b1;
        repeat (6) tick();

        // Long run phase saturates the width counter; ts wraps many times.
        mon_rst_n = 1'b1;
        repeat (20) tick();
        seen.delete();
        repeat (70000 - 20) tick();
        hold(1'b0, 10);
        check("sat_events", seen.size(), 1);
        if (seen.size() == 1) begin
            check("sat_kind", seen[0].kind, 0);
            check("sat_width", seen[0].width, CNT_MAX);
        end

        // Block reset with events queued and a sticky flag set.
        evt_ready = 1'b0;
        hold(1'b1, 10);
        hold(1'b0, 3);
        hold(1'b1, 10);
        check("pre_rst_count", evt_count, 3);
        check("pre_rst_err", err_short, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", evt_valid, 0);
        check("async_count", evt_count, 0);
        check("async_err", err_short, 0);
        check("async_ovf", overflow, 0);
        repeat (3) tick();
        mon_rst_n = 1'b0;
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        seen.delete();
        hold(1'b0, 17);
        hold(1'b1, 8);
        check("post_rst_events", seen.size(), 1);
        if (seen.size() == 1) begin
            check("post_rst_kind", seen[0].kind, 1);
            check("post_rst_width", seen[0].width, 20);
        end

        // Randomized phases, consumer stalls and sticky clears.
        for (int p = 0; p < 250; p++) begin
            mon_rst_n = ~mon_rst_n;
            for (int j = $urandom_range(1, 20); j > 0; j--) begin
                evt_ready  = ($urandom_range(0, 3) != 0);
                clr_sticky = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clr_sticky = 1'b0;
        evt_ready  = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
